axi_ad7124_cmd_buf: RTL and testbench
=====================================

# axi_ad7124_cmd_buf

Command-side companion of the AD7124 offload data buffer. Software fills a byte-addressable command memory through a 32-bit BRAM write port. On each `trigger` the block streams the first `cfg_length` bytes, in order, onto the SPI engine offload SDO interface, so that every conversion frame is preceded by a programmable command sequence. It sits between the AXI BRAM controller and the SPI engine offload SDO input, in the same clock domain as the SPI engine.

## Interface
- `BUFFER_ADDR_WIDTH`, 5: byte address width; memory holds 2**BUFFER_ADDR_WIDTH bytes. Must be ≥ 2.
- `clk` input 1: sole clock; SPI engine and BRAM port both run on it.
- `resetn` input 1: reset, asynchronous assert, active-low.
- `trigger` input 1: single-cycle start request.
- `cfg_length` input BUFFER_ADDR_WIDTH+1: frame length in bytes, sampled on an accepted trigger.
- `busy` output 1: a frame is in progress.
- `done` output 1: one-cycle pulse at frame end.
- `overrun` output 1: sticky flag for a trigger ignored while busy (see Configuration).
- `offload_sdo_valid` output 1: stream byte valid.
- `offload_sdo_ready` input 1: SPI engine accepts the byte.
- `offload_sdo_data` output 8: stream byte.
- `bram_en` input 1: BRAM port enable.
- `bram_we` input 4: per-byte write enables; bit k selects byte lane k.
- `bram_addr` input BUFFER_ADDR_WIDTH-2: word address.
- `bram_din` input 32: write data.
- `bram_dout` output 32: read-back data.

## Operation
- Byte map: word `a`, lane `k` (bits 8k+7:8k) ↔ byte address 4a+k. Memory contents are not reset.
- BRAM port: when `bram_en`, lanes with `bram_we[k]` set are written, and `bram_dout` loads the pre-write word at `bram_addr` (read-old-data). `bram_dout` holds its value while `bram_en` is low.
- States:
  - IDLE: `trigger` → capture length L = min(`cfg_length`, 2**BUFFER_ADDR_WIDTH). If L = 0, pulse `done` and stay in IDLE. Otherwise issue the fetch of byte 0 and go to FETCH.
  - FETCH: wait one cycle for read data, then go to SEND.
  - SEND: present bytes 0..L-1 in order. A byte is accepted when valid && ready. After the accept of byte L-1, go to IDLE and pulse `done`.
- Handshake: while valid is high and ready is low, data is held stable. Valid is never deasserted without an accept. Throughput with ready held high is one byte per clock, with no bubbles (prefetch/skid register required).
- Memory writes during a frame are allowed. Each streamed byte takes the memory value at the cycle that byte is fetched.
- `trigger` in FETCH or SEND: ignored, and the frame continues unchanged.
- `trigger` in the same cycle as the final accept: ignored. The next trigger is accepted only in IDLE.
- Reset asserted mid-frame: state goes to IDLE and all outputs go to their reset values immediately. The partial frame is abandoned.

## Timing
- Reset values: `busy`=0, `done`=0, `overrun`=0, `offload_sdo_valid`=0, `offload_sdo_data`=0, `bram_dout`=0.
- Trigger sampled at edge N (IDLE, L ≥ 1): `busy`=1 from N+1; `offload_sdo_valid`=1 from N+2.
- With ready held high, byte i is accepted at edge N+2+i.
- `busy` falls and `done` pulses one cycle after the last accept.
- L = 0: `done`=1 for the cycle after N; `busy` stays 0.
- BRAM read latency: 1 cycle.

## Configuration
- `AXI_AD7124_CMD_BUF_OVERRUN_EN`
  - Defined: a trigger ignored in FETCH or SEND sets `overrun`. It stays set until reset or until a trigger is accepted in IDLE, which clears it on the same edge.
  - Undefined: `overrun` is tied to 0. Ignored triggers leave no trace, and the streaming behaviour is otherwise identical.

## Test plan
- Write words 0x04030201 and 0x08070605 to addresses 0 and 1 with `bram_we`=0xF. Set `cfg_length`=8, ready high, trigger at N → bytes 01..08 accepted at N+2..N+9, `done` at N+10, `busy` high N+1..N+10.
- Same frame with ready toggling 1,0,0,1,… → bytes emitted in order with no loss or duplication, data stable while ready low, 8 accepts total.
- `cfg_length`=0 → `done` at N+1, `offload_sdo_valid` never asserts. `cfg_length`=63 with width 5 → exactly 32 bytes sent (addresses 0..31).
- Trigger again mid-frame → frame unaffected, `overrun`=1 with the macro defined and 0 without; next accepted trigger clears `overrun`.
- Write lane 2 only (`bram_we`=0x4, `bram_din`=0xAABBCCDD) over 0x04030201 → read-back 0x04BB0201 after the next read. Read during the write returns the old word.
- Assert `resetn` low while the 4th byte is pending → valid and busy drop immediately with no `done`. After release, a new trigger streams from byte 0.

Source files
------------

// File: rtl/axi_ad7124_cmd_buf.sv
// ---------------------------------------------------------------------------------------------
// axi_ad7124_cmd_buf
//
// Command-side companion of the AD7124 offload data buffer. Software fills a byte-addressable
// command memory through a 32-bit BRAM-style write port. On each trigger the first cfg_length
// bytes of that memory are streamed, in order, onto the SPI engine offload SDO interface, so
// that every conversion frame is preceded by a programmable command sequence.
//
// Ports (single clock domain, shared with the SPI engine):
//   clk                sole clock
//   resetn             asynchronous, active-low reset
//   trigger            single-cycle frame start request (accepted only when idle)
//   cfg_length         frame length in bytes, sampled on an accepted trigger, clamped to depth
//   busy               frame in progress (stays high through the done cycle)
//   done               one-cycle pulse at frame end
//   overrun            sticky: a trigger arrived while a frame was running
//   offload_sdo_valid  stream byte valid
//   offload_sdo_ready  SPI engine accepts the byte
//   offload_sdo_data   stream byte
//   bram_en            BRAM port enable
//   bram_we            per-byte-lane write enables (bit k -> bits 8k+7:8k)
//   bram_addr          word address
//   bram_din           write data
//   bram_dout          read-old-data, 1-cycle latency, held while bram_en is low
//
// Byte map: word a, lane k <-> byte address 4a+k. Memory contents are not reset.
//
// Build option:
//   AXI_AD7124_CMD_BUF_OVERRUN_EN  when defined, a trigger ignored in FETCH/SEND sets the
//                                  sticky overrun flag; an accepted trigger clears it.
//                                  When undefined, overrun is tied to 0.
// ---------------------------------------------------------------------------------------------

module axi_ad7124_cmd_buf #(
  parameter int unsigned BUFFER_ADDR_WIDTH = 5
) (
  input  logic                         clk,
  input  logic                         resetn,

  input  logic                         trigger,
  input  logic [BUFFER_ADDR_WIDTH:0]   cfg_length,
  output logic                         busy,
  output logic                         done,
  output logic                         overrun,

  output logic                         offload_sdo_valid,
  input  logic                         offload_sdo_ready,
  output logic [7:0]                   offload_sdo_data,

  input  logic                         bram_en,
  input  logic [3:0]                   bram_we,
  input  logic [BUFFER_ADDR_WIDTH-3:0] bram_addr,
  input  logic [31:0]                  bram_din,
  output logic [31:0]                  bram_dout
);

  localparam int unsigned AW       = BUFFER_ADDR_WIDTH;
  localparam int unsigned NumWords = 2 ** (AW - 2);

  localparam logic [AW:0] LenZero = '0;
  localparam logic [AW:0] LenOne  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW:0] MaxLen  = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle, StFetch, StSend} state_e;

  // -------------------------------------------------------------------------------------------
  // Command memory
  // -------------------------------------------------------------------------------------------
  logic [31:0] mem [NumWords];

  always_ff @(posedge clk) begin
    if (bram_en) begin
      for (int k = 0; k < 4; k++) begin
        if (bram_we[k]) begin
          mem[bram_addr][8*k +: 8] <= bram_din[8*k +: 8];
        end
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  state_e      state_q, state_d;
  logic [AW:0] len_q, len_d;       // bytes in the current frame
  logic [AW:0] ptr_q, ptr_d;       // next byte address to fetch into the output register
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [31:0] bram_dout_q, bram_dout_d;

  // Stream fetch path. The output register is loaded directly from memory on the edge the
  // byte is fetched, so each byte carries the memory value of that cycle and, with ready high,
  // the next byte is already in place on the edge the current one is accepted.
  logic [AW-1:0] fetch_addr;
  logic [31:0]   fetch_word;
  logic [7:0]    fetch_byte;
  logic [AW:0]   len_clamped;

  always_comb begin
    fetch_addr  = (state_q == StIdle) ? '0 : ptr_q[AW-1:0];
    fetch_word  = mem[fetch_addr[AW-1:2]];
    fetch_byte  = fetch_word[{fetch_addr[1:0], 3'b000} +: 8];
    len_clamped = (cfg_length > MaxLen) ? MaxLen : cfg_length;
  end

  // -------------------------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    ptr_d       = ptr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bram_dout_d = bram_en ? mem[bram_addr] : bram_dout_q;

    unique case (state_q)
      StIdle: begin
        // busy may still be high here for the done cycle of the previous frame
        busy_d = 1'b0;
        if (trigger) begin
          if (cfg_length == LenZero) begin
            done_d = 1'b1;
          end else begin
            len_d   = len_clamped;
            data_d  = fetch_byte;
            ptr_d   = LenOne;
            busy_d  = 1'b1;
            state_d = StFetch;
          end
        end
      end

      StFetch: begin
        valid_d = 1'b1;
        state_d = StSend;
      end

      StSend: begin
        if (valid_q && offload_sdo_ready) begin
          if (ptr_q == len_q) begin
            // Last byte accepted; busy is left high so it covers the done cycle.
            valid_d = 1'b0;
            done_d  = 1'b1;
            state_d = StIdle;
          end else begin
            data_d = fetch_byte;
            ptr_d  = ptr_q + LenOne;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      len_q       <= '0;
      ptr_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bram_dout_q <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      ptr_q       <= ptr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bram_dout_q <= bram_dout_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Overrun flag
  // -------------------------------------------------------------------------------------------
`ifdef AXI_AD7124_CMD_BUF_OVERRUN_EN
  logic overrun_q, overrun_d;

  always_comb begin
    overrun_d = overrun_q;
    if (trigger) begin
      // accepted in idle clears; ignored while a frame runs sets
      overrun_d = (state_q != StIdle);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  assign busy              = busy_q;
  assign done              = done_q;
  assign offload_sdo_valid = valid_q;
  assign offload_sdo_data  = data_q;
  assign bram_dout         = bram_dout_q;

endmodule

// File: tb/tb_axi_ad7124_cmd_buf.sv
// Directed testbench for axi_ad7124_cmd_buf. Inputs are driven and outputs sampled on the
// falling edge; "at edge N+k" below means the value seen just before rising edge N+k, where
// N is the edge that samples the trigger.
module tb_axi_ad7124_cmd_buf;

  localparam int unsigned AW = 5;

`ifdef AXI_AD7124_CMD_BUF_OVERRUN_EN
  localparam logic OvrExp = 1'b1;
`else
  localparam logic OvrExp = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          resetn;
  logic          trigger;
  logic [AW:0]   cfg_length;
  logic          busy;
  logic          done;
  logic          overrun;
  logic          valid;
  logic          ready;
  logic [7:0]    data;
  logic          bram_en;
  logic [3:0]    bram_we;
  logic [AW-3:0] bram_addr;
  logic [31:0]   bram_din;
  logic [31:0]   bram_dout;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  axi_ad7124_cmd_buf #(
    .BUFFER_ADDR_WIDTH(AW)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .trigger          (trigger),
    .cfg_length       (cfg_length),
    .busy             (busy),
    .done             (done),
    .overrun          (overrun),
    .offload_sdo_valid(valid),
    .offload_sdo_ready(ready),
    .offload_sdo_data (data),
    .bram_en          (bram_en),
    .bram_we          (bram_we),
    .bram_addr        (bram_addr),
    .bram_din         (bram_din),
    .bram_dout        (bram_dout)
  );

  // ---- stimulus helpers (start and end on a falling edge) ----
  task automatic bram_write(input logic [AW-3:0] addr, input logic [3:0] we,
                            input logic [31:0] din);
    bram_en = 1'b1; bram_we = we; bram_addr = addr; bram_din = din;
    @(negedge clk);
    bram_en = 1'b0; bram_we = 4'h0;
  endtask

  task automatic bram_read(input logic [AW-3:0] addr);
    bram_en = 1'b1; bram_we = 4'h0; bram_addr = addr;
    @(negedge clk);
    bram_en = 1'b0;
  endtask

  // Returns at the sample point for edge N+1.
  task automatic pulse_trigger(input logic [AW:0] len);
    cfg_length = len; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy);
    else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done);
    else n_pass++;
    n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun);
    else n_pass++;
    n_checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid);
    else n_pass++;
    n_checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h expected 00", data);
    else n_pass++;
    n_checks++; if (bram_dout !== 32'h0) $display("FAIL reset_dout: got %h expected 0", bram_dout);
    else n_pass++;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_bram();
    bram_write(3'd0, 4'hF, 32'h04030201);
    bram_write(3'd1, 4'hF, 32'h08070605);
    bram_read(3'd0);
    n_checks++; if (bram_dout !== 32'h04030201)
      $display("FAIL bram_rd0: got %h expected 04030201", bram_dout);
    else n_pass++;
    bram_write(3'd0, 4'h4, 32'hAABBCCDD);
    n_checks++; if (bram_dout !== 32'h04030201)
      $display("FAIL bram_rd_old: got %h expected 04030201", bram_dout);
    else n_pass++;
    @(negedge clk);
    n_checks++; if (bram_dout !== 32'h04030201)
      $display("FAIL bram_hold: got %h expected 04030201", bram_dout);
    else n_pass++;
    bram_read(3'd0);
    n_checks++; if (bram_dout !== 32'h04BB0201)
      $display("FAIL bram_lane2: got %h expected 04bb0201", bram_dout);
    else n_pass++;
    bram_read(3'd1);
    n_checks++; if (bram_dout !== 32'h08070605)
      $display("FAIL bram_rd1: got %h expected 08070605", bram_dout);
    else n_pass++;
    bram_write(3'd0, 4'hF, 32'h04030201);
  endtask

  task automatic test_stream_full();
    ready = 1'b1;
    pulse_trigger(6'd8);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      n_checks++; if (busy !== (k <= 10))
        $display("FAIL full_busy k=%0d: got %b expected %b", k, busy, (k <= 10));
      else n_pass++;
      n_checks++; if (valid !== (k >= 2 && k <= 9))
        $display("FAIL full_valid k=%0d: got %b expected %b", k, valid, (k >= 2 && k <= 9));
      else n_pass++;
      n_checks++; if (done !== (k == 10))
        $display("FAIL full_done k=%0d: got %b expected %b", k, done, (k == 10));
      else n_pass++;
      if (k >= 2 && k <= 9) begin
        n_checks++; if (data !== 8'(k - 1))
          $display("FAIL full_data k=%0d: got %h expected %h", k, data, 8'(k - 1));
        else n_pass++;
      end
    end
  endtask

  task automatic test_ready_toggle();
    int   n_acc = 0;
    logic stall_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic seen_done = 1'b0;
    ready = 1'b1;
    pulse_trigger(6'd8);
    for (int c = 0; c < 60; c++) begin
      ready = (c % 3 == 0);
      if (stall_prev) begin
        n_checks++; if ({valid, data} !== {1'b1, prev_data})
          $display("FAIL tog_stable c=%0d: got %b/%h expected 1/%h", c, valid, data, prev_data);
        else n_pass++;
      end
      if (valid && ready) begin
        n_checks++; if (data !== 8'(n_acc + 1))
          $display("FAIL tog_data #%0d: got %h expected %h", n_acc, data, 8'(n_acc + 1));
        else n_pass++;
        n_acc++;
      end
      stall_prev = valid && !ready;
      prev_data  = data;
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    ready = 1'b1;
    n_checks++; if (n_acc !== 8) $display("FAIL tog_count: got %0d expected 8", n_acc);
    else n_pass++;
    n_checks++; if (seen_done !== 1'b1) $display("FAIL tog_done: got %b expected 1", seen_done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_len_zero();
    logic saw_valid;
    ready = 1'b1;
    pulse_trigger(6'd0);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b expected 1", done);
    else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b expected 0", busy);
    else n_pass++;
    saw_valid = valid;
    @(negedge clk);
    n_checks++; if (done !== 1'b0) $display("FAIL zero_done_end: got %b expected 0", done);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      saw_valid |= valid;
      @(negedge clk);
    end
    n_checks++; if (saw_valid !== 1'b0) $display("FAIL zero_valid: got %b expected 0", saw_valid);
    else n_pass++;
  endtask

  task automatic test_len_max();
    int   n_acc = 0;
    logic seen_done = 1'b0;
    for (int a = 0; a < 8; a++) begin
      bram_write(3'(a), 4'hF, {8'(4*a + 4), 8'(4*a + 3), 8'(4*a + 2), 8'(4*a + 1)});
    end
    ready = 1'b1;
    pulse_trigger(6'd63);
    for (int c = 0; c < 80; c++) begin
      if (valid && ready) begin
        n_checks++; if (data !== 8'(n_acc + 1))
          $display("FAIL max_data #%0d: got %h expected %h", n_acc, data, 8'(n_acc + 1));
        else n_pass++;
        n_acc++;
      end
      if (done) begin
        seen_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_checks++; if (n_acc !== 32) $display("FAIL max_count: got %0d expected 32", n_acc);
    else n_pass++;
    n_checks++; if (seen_done !== 1'b1) $display("FAIL max_done: got %b expected 1", seen_done);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_overrun();
    ready = 1'b1;
    pulse_trigger(6'd8);
    for (int k = 1; k <= 11; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 4) begin
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_pre: got %b expected 0", overrun);
        else n_pass++;
        cfg_length = 6'd0; trigger = 1'b1;
      end
      if (k == 5) begin
        trigger = 1'b0;
        n_checks++; if (overrun !== OvrExp)
          $display("FAIL ovr_set: got %b expected %b", overrun, OvrExp);
        else n_pass++;
      end
      n_checks++; if (valid !== (k >= 2 && k <= 9))
        $display("FAIL ovr_valid k=%0d: got %b expected %b", k, valid, (k >= 2 && k <= 9));
      else n_pass++;
      n_checks++; if (done !== (k == 10))
        $display("FAIL ovr_done k=%0d: got %b expected %b", k, done, (k == 10));
      else n_pass++;
      if (k >= 2 && k <= 9) begin
        n_checks++; if (data !== 8'(k - 1))
          $display("FAIL ovr_data k=%0d: got %h expected %h", k, data, 8'(k - 1));
        else n_pass++;
      end
    end
    n_checks++; if (overrun !== OvrExp)
      $display("FAIL ovr_sticky: got %b expected %b", overrun, OvrExp);
    else n_pass++;
    pulse_trigger(6'd0);
    n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun);
    else n_pass++;
    n_checks++; if (done !== 1'b1) $display("FAIL ovr_clear_done: got %b expected 1", done);
    else n_pass++;
    @(negedge clk);
  endtask

  // Trigger coincident with the final accept is ignored; one in the done cycle is accepted.
  task automatic test_back_to_back();
    ready = 1'b1;
    pulse_trigger(6'd4);
    repeat (4) @(negedge clk);           // sample point of edge N+5, last accept
    cfg_length = 6'd4; trigger = 1'b1;
    @(negedge clk);                      // N+6
    trigger = 1'b0;
    n_checks++; if ({done, busy, valid} !== 3'b110)
      $display("FAIL b2b_end: got %b expected 110", {done, busy, valid});
    else n_pass++;
    n_checks++; if (overrun !== OvrExp)
      $display("FAIL b2b_ovr: got %b expected %b", overrun, OvrExp);
    else n_pass++;
    @(negedge clk);                      // N+7
    n_checks++; if ({busy, valid} !== 2'b00)
      $display("FAIL b2b_norestart: got %b expected 00", {busy, valid});
    else n_pass++;
    pulse_trigger(6'd2);
    n_checks++; if ({busy, overrun} !== 2'b10)
      $display("FAIL b2b_start: got %b expected 10", {busy, overrun});
    else n_pass++;
    @(negedge clk);
    n_checks++; if ({valid, data} !== {1'b1, 8'h01})
      $display("FAIL b2b_byte0: got %b/%h expected 1/01", valid, data);
    else n_pass++;
    @(negedge clk);
    n_checks++; if ({valid, data} !== {1'b1, 8'h02})
      $display("FAIL b2b_byte1: got %b/%h expected 1/02", valid, data);
    else n_pass++;
    @(negedge clk);
    n_checks++; if ({done, valid} !== 2'b10)
      $display("FAIL b2b_done: got %b expected 10", {done, valid});
    else n_pass++;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    ready = 1'b1;
    pulse_trigger(6'd8);
    repeat (4) @(negedge clk);           // edge N+5: 4th byte pending
    n_checks++; if ({valid, data} !== {1'b1, 8'h04})
      $display("FAIL rst_pending: got %b/%h expected 1/04", valid, data);
    else n_pass++;
    #1 resetn = 1'b0;
    #1;
    n_checks++; if ({valid, busy, done} !== 3'b000)
      $display("FAIL rst_async: got %b expected 000", {valid, busy, done});
    else n_pass++;
    n_checks++; if (data !== 8'h00) $display("FAIL rst_data: got %h expected 00", data);
    else n_pass++;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    n_checks++; if ({valid, busy, done} !== 3'b000)
      $display("FAIL rst_after: got %b expected 000", {valid, busy, done});
    else n_pass++;
    pulse_trigger(6'd8);
    @(negedge clk);
    n_checks++; if ({valid, data} !== {1'b1, 8'h01})
      $display("FAIL rst_restart: got %b/%h expected 1/01", valid, data);
    else n_pass++;
    repeat (12) @(negedge clk);
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_idle: got %b expected 0", busy);
    else n_pass++;
  endtask

  initial begin
    resetn     = 1'b1;
    trigger    = 1'b0;
    cfg_length = '0;
    ready      = 1'b0;
    bram_en    = 1'b0;
    bram_we    = 4'h0;
    bram_addr  = '0;
    bram_din   = '0;
    #2 resetn  = 1'b0;
    test_reset();
    test_bram();
    test_stream_full();
    test_ready_toggle();
    test_len_zero();
    test_len_max();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
